// File: rtl/lcd_pkg.sv
// Shared encodings and HD44780 command constants for the LCD refresh controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        INIT,
        L1_ADDR,
        L1_CHAR,
        L2_ADDR,
        L2_CHAR
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } phase_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] LINE1_ADDR   = 8'h80;
    localparam logic [7:0] LINE2_ADDR   = 8'hC0;
    localparam int         INIT_CMDS      = 4;
    localparam int         CHARS_PER_LINE = 16;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    init_cmd = CMD_FUNC_SET;
            2'd1:    init_cmd = CMD_DISP_ON;
            2'd2:    init_cmd = CMD_CLEAR;
            default: init_cmd = CMD_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/lcd_byte_phy.sv
// One LCD byte write: SETUP 1 cycle, EN high EN_CYC, then HOLD of CMD_CYC or CLR_CYC.
// start is taken only while idle; done flags the last HOLD cycle.
module lcd_byte_phy
    import lcd_pkg::*;
#(
    parameter int EN_CYC  = 16,
    parameter int CMD_CYC = 2500,
    parameter int CLR_CYC = 100000
) (
    input  logic       rst,
    input  logic       cpu_clk,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       busy,
    output logic       done,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic [7:0] LCD_DATA
);
    localparam int MAX_WAIT = (CLR_CYC > CMD_CYC) ? CLR_CYC : CMD_CYC;
    localparam int MAX_CNT  = (MAX_WAIT > EN_CYC) ? MAX_WAIT : EN_CYC;
    localparam int CW       = $clog2(MAX_CNT + 1);

    phase_t          phase;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   hold_last;
    logic            long_r;

    assign hold_last = long_r ? CW'(CLR_CYC - 1) : CW'(CMD_CYC - 1);
    assign busy      = (phase != PH_IDLE);
    assign done      = (phase == PH_HOLD) && (cnt == hold_last);

    // LCD_DATA/LCD_RS are loaded only on acceptance, so they hold through HOLD.
    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            phase    <= PH_IDLE;
            cnt      <= '0;
            long_r   <= 1'b0;
            LCD_EN   <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= 8'h00;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        phase    <= PH_SETUP;
                        LCD_RS   <= rs;
                        LCD_DATA <= data;
                        long_r   <= long_wait;
                    end
                end
                PH_SETUP: begin
                    phase  <= PH_PULSE;
                    LCD_EN <= 1'b1;
                    cnt    <= '0;
                end
                PH_PULSE: begin
                    if (cnt == CW'(EN_CYC - 1)) begin
                        phase  <= PH_HOLD;
                        LCD_EN <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_HOLD: begin
                    if (cnt == hold_last) begin
                        phase <= PH_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// HD44780 2x16 controller: CPU-visible 32-byte buffer (1-cycle read), power-up init,
// then endless refresh of both lines. CPU access and the refresh FSM never stall each other.
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int PWRUP_CYC = 750000,
    parameter int EN_CYC    = 16,
    parameter int CMD_CYC   = 2500,
    parameter int CLR_CYC   = 100000
) (
    input  logic        rst,
    input  logic        cpu_clk,
    input  logic        cs,
    input  logic        we,
    input  logic [4:0]  adrs,
    input  logic [15:0] from_cpu,
    output logic [15:0] to_cpu,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_RW,
    output logic        LCD_EN,
    output logic        LCD_RS
);
    localparam int PW = $clog2(PWRUP_CYC + 1);

    logic [7:0]    char_buf [32];
    state_t        state;
    logic [PW-1:0] pw_cnt;
    logic [1:0]    init_idx;
    logic [4:0]    idx;
    logic          start;
    logic          rs;
    logic [7:0]    cmd;
    logic [7:0]    phy_data;
    logic          long_wait;
    logic          phy_busy;
    logic          done;
    logic          unused_bits;

    assign LCD_RW      = 1'b0;
    assign unused_bits = ^{from_cpu[15:8], phy_busy};

    // Characters are read live here and captured by the phy as SETUP begins.
    assign phy_data  = rs ? char_buf[idx] : cmd;
    assign long_wait = !rs && (cmd == CMD_CLEAR);

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) char_buf[i] <= 8'h20;
            to_cpu <= 16'h0000;
        end else begin
            if (cs && we) char_buf[adrs] <= from_cpu[7:0];
            to_cpu <= {8'h00, char_buf[adrs]};
        end
    end

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            state    <= PWRUP;
            pw_cnt   <= '0;
            init_idx <= '0;
            idx      <= '0;
            start    <= 1'b0;
            rs       <= 1'b0;
            cmd      <= 8'h00;
        end else begin
            start <= 1'b0;
            case (state)
                PWRUP: begin
                    if (pw_cnt == PW'(PWRUP_CYC - 1)) begin
                        state <= INIT;
                        start <= 1'b1;
                        rs    <= 1'b0;
                        cmd   <= init_cmd(2'd0);
                    end else begin
                        pw_cnt <= pw_cnt + 1'b1;
                    end
                end
                INIT: begin
                    if (done) begin
                        start <= 1'b1;
                        if (init_idx == 2'(INIT_CMDS - 1)) begin
                            state <= L1_ADDR;
                            cmd   <= LINE1_ADDR;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                            cmd      <= init_cmd(init_idx + 2'd1);
                        end
                    end
                end
                L1_ADDR: begin
                    if (done) begin
                        state <= L1_CHAR;
                        start <= 1'b1;
                        rs    <= 1'b1;
                    end
                end
                L1_CHAR: begin
                    if (done) begin
                        start <= 1'b1;
                        idx   <= idx + 5'd1;
                        if (idx == 5'(CHARS_PER_LINE - 1)) begin
                            state <= L2_ADDR;
                            rs    <= 1'b0;
                            cmd   <= LINE2_ADDR;
                        end
                    end
                end
                L2_ADDR: begin
                    if (done) begin
                        state <= L2_CHAR;
                        start <= 1'b1;
                        rs    <= 1'b1;
                    end
                end
                L2_CHAR: begin
                    if (done) begin
                        start <= 1'b1;
                        idx   <= idx + 5'd1;
                        if (idx == 5'd31) begin
                            state <= L1_ADDR;
                            rs    <= 1'b0;
                            cmd   <= LINE1_ADDR;
                        end
                    end
                end
                default: state <= PWRUP;
            endcase
        end
    end

    lcd_byte_phy #(
        .EN_CYC  (EN_CYC),
        .CMD_CYC (CMD_CYC),
        .CLR_CYC (CLR_CYC)
    ) u_phy (
        .rst       (rst),
        .cpu_clk   (cpu_clk),
        .start     (start),
        .rs        (rs),
        .data      (phy_data),
        .long_wait (long_wait),
        .busy      (phy_busy),
        .done      (done),
        .LCD_EN    (LCD_EN),
        .LCD_RS    (LCD_RS),
        .LCD_DATA  (LCD_DATA)
    );

endmodule
